arbiter: RTL and testbench

// - N-way round-robin arbiter with a registered one-hot grant.
// - Each clock it picks one active requester, rotating priority so the

---
 rtl/arbiter_pkg.sv | 58 +++++
 rtl/arbiter_prio_pick.sv | 73 +++++++
 rtl/arbiter.sv | 121 ++++++++++++
 tb/tb_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arbiter_pkg
// Shared types, sizing helpers and the round-robin reference pick function
// used by the arbiter slice.
//
// Contents:
//   MAX_N / IDX_W  - widest supported requester count and its index width
//   pick_t         - result of a round-robin search (valid + winning index)
//   ptr_width(n)   - width of the last-grant pointer, $clog2(n) but never 0
//   rr_pick(...)   - plain sequential round-robin search: starting just after
//                    ptr, walk n positions with wrap and return the first
//                    active requester
//
// Optional feature macro used by the slice: ARBITER_SVA_EN
// ----------------------------------------------------------------------------
package arbiter_pkg;

    localparam int MAX_N = 32;
    localparam int IDX_W = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // A one-requester pointer would be zero bits wide, so clamp to 1.
    function automatic int ptr_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Search (ptr+1+k) mod n for k = 0..n-1; the first set request wins.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [IDX_W-1:0] ptr,
                                      input int               n);
        pick_t r;
        int    idx;
        r.valid = 1'b0;
        r.idx   = {IDX_W{1'b0}};
        for (int k = 0; k < MAX_N; k++) begin
            idx = (int'(ptr) + 1 + k) % n;
            if ((k < n) && !r.valid && req[idx]) begin
                r.valid = 1'b1;
                r.idx   = idx[IDX_W-1:0];
            end else begin
                r.valid = r.valid;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbiter_prio_pick.sv
// ----------------------------------------------------------------------------
// arbiter_prio_pick
// Combinational round-robin selector built as a double-width priority
// encoder. The low half holds the requests strictly above ptr, the high half
// holds all requests; the lowest set bit of the concatenation is therefore
// the first requester after ptr, wrapping to index 0 when none lie above it.
//
// Ports:
//   req_i        [N-1:0]      request vector
//   ptr_i        [PTR_W-1:0]  index of the last winner
//   next_grant_o [N-1:0]      one-hot winner, zero when no request
//   next_idx_o   [PTR_W-1:0]  index of the winner (0 when no request)
//   any_req_o                 at least one request is active
// ----------------------------------------------------------------------------
module arbiter_prio_pick
    import arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     next_grant_o,
    output logic [PTR_W-1:0] next_idx_o,
    output logic             any_req_o
);

    logic [N-1:0]   mask_s;
    logic [2*N-1:0] dbl_s;
    logic [PTR_W:0] pos_s;
    logic [PTR_W:0] idx_full_s;
    logic           found_s;

    // Keep only positions strictly above the last winner.
    always_comb begin
        mask_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (i > int'(ptr_i)) ? 1'b1 : 1'b0;
        end
    end

    // Lowest set bit of {all requests, masked requests}; scanning downward
    // lets the last hit (the lowest index) win.
    always_comb begin
        dbl_s   = {req_i, req_i & mask_s};
        pos_s   = {(PTR_W+1){1'b0}};
        found_s = 1'b0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl_s[i]) begin
                pos_s   = i[PTR_W:0];
                found_s = 1'b1;
            end else begin
                pos_s   = pos_s;
                found_s = found_s;
            end
        end
    end

    // Fold a hit in the unmasked upper half back onto a requester index.
    always_comb begin
        if (pos_s >= (PTR_W+1)'(N)) begin
            idx_full_s = pos_s - (PTR_W+1)'(N);
        end else begin
            idx_full_s = pos_s;
        end
    end

    assign any_req_o    = found_s;
    assign next_idx_o   = idx_full_s[PTR_W-1:0];
    assign next_grant_o = found_s ? ({{(N-1){1'b0}}, 1'b1} << next_idx_o)
                                  : {N{1'b0}};

endmodule

// File: rtl/arbiter.sv
// ----------------------------------------------------------------------------
// arbiter
// N-way round-robin arbiter with a registered one-hot grant. The requester
// granted last becomes lowest priority on the next edge; the grant is a flop
// so it can drive long routes directly. Arbitration is recomputed every edge.
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-low reset (clears grant and pointer)
//   req    [N-1:0] request vector, bit i = agent i requesting
//   grant  [N-1:0] registered grant, one-hot or all-zero
//
// Build option: define ARBITER_SVA_EN to compile in the protocol checker
// (arbiter_checker below). Functional logic is identical either way.
// ----------------------------------------------------------------------------
module arbiter
    import arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = ptr_width(N);

    logic [N-1:0]     grant_q;
    logic [N-1:0]     grant_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [N-1:0]     next_grant_s;
    logic [PTR_W-1:0] next_idx_s;
    logic             any_req_s;

    arbiter_prio_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .next_grant_o (next_grant_s),
        .next_idx_o   (next_idx_s),
        .any_req_o    (any_req_s)
    );

    // Next state: a winner moves the pointer; an idle cycle only clears grant.
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (any_req_s) begin
            grant_d = next_grant_s;
            ptr_d   = next_idx_s;
        end else begin
            grant_d = {N{1'b0}};
            ptr_d   = ptr_q;
        end
    end

    // Grant and last-winner pointer flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= {N{1'b0}};
            ptr_q   <= {PTR_W{1'b0}};
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

`ifdef ARBITER_SVA_EN
    arbiter_checker #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_chk (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (req),
        .grant_i (grant_q),
        .ptr_i   (ptr_q)
    );
`endif

endmodule

`ifdef ARBITER_SVA_EN
// ----------------------------------------------------------------------------
// arbiter_checker
// Concurrent protocol properties for arbiter. Properties that refer to the
// previous request also require the previous cycle to be out of reset, since
// the first edge after release still shows the reset-cleared grant.
// ----------------------------------------------------------------------------
module arbiter_checker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input logic             clk_i,
    input logic             reset_i,
    input logic [N-1:0]     req_i,
    input logic [N-1:0]     grant_i,
    input logic [PTR_W-1:0] ptr_i
);

    a_onehot: assert property (@(posedge clk_i) disable iff (!reset_i)
        $onehot0(grant_i));

    a_grant_subset: assert property (@(posedge clk_i) disable iff (!reset_i)
        $past(reset_i) |-> ((grant_i & ~$past(req_i)) == {N{1'b0}}));

    a_req_served: assert property (@(posedge clk_i) disable iff (!reset_i)
        ($past(reset_i) && ($past(req_i) != {N{1'b0}})) |-> (grant_i != {N{1'b0}}));

    a_idle_hold: assert property (@(posedge clk_i) disable iff (!reset_i)
        ($past(reset_i) && ($past(req_i) == {N{1'b0}}))
            |-> ((grant_i == {N{1'b0}}) && $stable(ptr_i)));

endmodule
`endif

// File: tb/tb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_arbiter
// Directed scenarios for a 4-way arbiter followed by 1000 cycles of random
// requests compared against the package round-robin search (rr_pick).
// ----------------------------------------------------------------------------
module tb_arbiter;
    import arbiter_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;

    int vectors;
    int miscompares;
    int model_ptr;

    arbiter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] expv);
        vectors++;
        assert (grant === expv) else begin
            miscompares++;
            $error("FAIL %s: grant=%b expected=%b", tag, grant, expv);
        end
    endtask

    // Drive req, take one edge, compare 1 time unit after it.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] expv, input string tag);
        req = r;
        @(posedge clk);
        #1;
        check(tag, expv);
    endtask

    initial begin
        pick_t         p;
        logic [N-1:0]  expv;
        logic [N-1:0]  r;
        logic [MAX_N-1:0] req_wide;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        req         = 4'b0000;

        // Held in reset with requests toggling.
        step(4'b1111, 4'b0000, "reset_hold0");
        step(4'b0000, 4'b0000, "reset_hold1");
        step(4'b1111, 4'b0000, "reset_hold2");
        step(4'b1111, 4'b0000, "reset_hold3");
        reset = 1'b1;

        // Full rotation starting at index 1.
        step(4'b1111, 4'b0010, "rot0");
        step(4'b1111, 4'b0100, "rot1");
        step(4'b1111, 4'b1000, "rot2");
        step(4'b1111, 4'b0001, "rot3");
        step(4'b1111, 4'b0010, "rot4");

        // Idle hold keeps ptr at 1.
        step(4'b0000, 4'b0000, "idle");
        step(4'b1111, 4'b0100, "idle_resume");

        // Wrap and skip.
        step(4'b1111, 4'b1000, "to_ptr3");
        step(4'b1010, 4'b0010, "wrap_skip");
        step(4'b1001, 4'b1000, "skip_to3");
        step(4'b1000, 4'b1000, "single_again");

        // Reset mid-stream.
        step(4'b1111, 4'b0001, "mid0");
        step(4'b1111, 4'b0010, "mid1");
        step(4'b1111, 4'b0100, "mid2");
        #2;
        reset = 1'b0;
        #1;
        check("async_clear", 4'b0000);
        #1;
        reset = 1'b1;
        step(4'b1111, 4'b0010, "after_reset");

        // Random traffic against the reference search; ptr is now 1.
        model_ptr = 1;
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 4'b0000;
            end else begin
                r = 4'($urandom_range(0, 15));
            end
            req_wide = {{(MAX_N-N){1'b0}}, r};
            p = rr_pick(req_wide, 5'(model_ptr), N);
            if (p.valid) begin
                expv      = 4'b0001 << p.idx;
                model_ptr = int'(p.idx);
            end else begin
                expv = 4'b0000;
            end
            step(r, expv, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
